// File: rtl/sr_drive_pkg.sv
// Shared types and constants for the SR flip-flop drive sequencer.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/sr_cycle_timer.sv
// Loadable down-counter used to time the hold and gap phases.
module sr_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  // A phase ends during the cycle in which its last count is held.
  assign expired_o = (value_q <= CNT_W'(1));
  assign value_o   = value_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command sequencer driving SR flip-flop S/R inputs with hold, quiet gap and Q check.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8,
  parameter int OPS_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [OPS_W-1:0] ops_cnt
);

  if (CNT_W < 1 || OPS_W < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 ||
      HOLD_CYCLES > (2 ** CNT_W) - 1 || GAP_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("sr_drive_ctrl: illegal parameter value");
  end

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [OPS_W-1:0] ops_q, ops_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_dec;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expired;

  sr_cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .dec_i     (timer_dec),
    .value_o   (timer_value),
    .expired_o (timer_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= OP_CLR;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  // S and R are both derived from a single op bit, so they can never be high together.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    ops_d      = ops_q;
    timer_load = 1'b0;
    timer_val  = CNT_W'(HOLD_CYCLES);
    timer_dec  = 1'b0;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          state_d    = DRIVE;
          timer_load = 1'b1;
          s_d        = (req_op == OP_SET);
          r_d        = (req_op == OP_CLR);
        end
      end
      DRIVE: begin
        if (timer_expired) begin
          state_d    = GAP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(GAP_CYCLES);
        end else begin
          timer_dec = (timer_value != '0);
          s_d       = (op_q == OP_SET);
          r_d       = (op_q == OP_CLR);
        end
      end
      GAP: begin
        if (timer_expired) begin
          state_d = CHECK;
          done_d  = 1'b1;
        end else begin
          timer_dec = (timer_value != '0);
        end
      end
      CHECK: begin
        state_d = IDLE;
        ops_d   = ops_q + 1'b1;
        // Unknown feedback is treated as a failure, and a failure beats a clear.
        if (q_fb !== op_q) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign S         = s_q;
  assign R         = r_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ops_cnt   = ops_q;

endmodule
